// File: rtl/ahb_mst_arb_if.sv
// ahb_mst_arb_if: bundle of NM requester-side (m_*) and one shared slave-side (s_*) AHB-Lite signal set; master = arbiter view, slave = environment view
interface ahb_mst_arb_if #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 64
);
  localparam int MW = (NM > 1) ? $clog2(NM) : 1;
  logic [NM*2-1:0]  m_htrans;
  logic [NM*AW-1:0] m_haddr;
  logic [NM-1:0]    m_hwrite;
  logic [NM*3-1:0]  m_hsize;
  logic [NM*3-1:0]  m_hburst;
  logic [NM*4-1:0]  m_hprot;
  logic [NM-1:0]    m_hmastlock;
  logic [NM*DW-1:0] m_hwdata;
  logic [NM-1:0]    m_hready;
  logic [NM-1:0]    m_hresp;
  logic [DW-1:0]    m_hrdata;
  logic [1:0]       s_htrans;
  logic [AW-1:0]    s_haddr;
  logic             s_hwrite;
  logic [2:0]       s_hsize;
  logic [2:0]       s_hburst;
  logic [3:0]       s_hprot;
  logic             s_hmastlock;
  logic [DW-1:0]    s_hwdata;
  logic             s_hsel;
  logic [MW-1:0]    s_hmaster;
  logic             s_hreadym;
  logic             s_hready;
  logic             s_hresp;
  logic [DW-1:0]    s_hrdata;
  modport master (
    input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_hmastlock, m_hwdata,
    input  s_hready, s_hresp, s_hrdata,
    output m_hready, m_hresp, m_hrdata,
    output s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock, s_hwdata,
    output s_hsel, s_hmaster, s_hreadym
  );
  modport slave (
    output m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_hmastlock, m_hwdata,
    output s_hready, s_hresp, s_hrdata,
    input  m_hready, m_hresp, m_hrdata,
    input  s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_hmastlock, s_hwdata,
    input  s_hsel, s_hmaster, s_hreadym
  );
endinterface

// File: rtl/ahb_mst_arb.sv
// ahb_mst_arb: round-robin AHB-Lite multi-master arbiter; ports clk, resetn (sync, active-low), bus (master modport: m_* requesters in, s_* shared port out)
module ahb_mst_arb #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          resetn,
  ahb_mst_arb_if.master bus
);
  localparam int MW = (NM > 1) ? $clog2(NM) : 1;
  logic [MW-1:0] aowner_q, aowner_d, downer_q, downer_d, win;
  logic          dvld_q, dvld_d, found;
  logic [NM-1:0] req;
  logic [1:0]    own_trans;
  assign own_trans       = bus.m_htrans[2*aowner_q +: 2];
  assign bus.s_htrans    = resetn ? own_trans : 2'b00;
  assign bus.s_haddr     = bus.m_haddr[AW*aowner_q +: AW];
  assign bus.s_hwrite    = bus.m_hwrite[aowner_q];
  assign bus.s_hsize     = bus.m_hsize[3*aowner_q +: 3];
  assign bus.s_hburst    = bus.m_hburst[3*aowner_q +: 3];
  assign bus.s_hprot     = bus.m_hprot[4*aowner_q +: 4];
  assign bus.s_hmastlock = resetn & bus.m_hmastlock[aowner_q];
  assign bus.s_hwdata    = bus.m_hwdata[DW*downer_q +: DW];
  assign bus.s_hsel      = bus.s_htrans[1];
  assign bus.s_hmaster   = aowner_q;
  assign bus.s_hreadym   = bus.s_hready;
  assign bus.m_hrdata    = bus.s_hrdata;
  always_comb begin
    for (int i = 0; i < NM; i++) req[i] = bus.m_htrans[2*i+1];
  end
  always_comb begin
    for (int i = 0; i < NM; i++) begin
      bus.m_hready[i] = !resetn || ((MW'(i) == aowner_q || (dvld_q && MW'(i) == downer_q)) ? bus.s_hready : !req[i]);
      bus.m_hresp[i]  = resetn && dvld_q && MW'(i) == downer_q && bus.s_hresp;
    end
  end
  always_comb begin
    win   = aowner_q;
    found = 1'b0;
    for (int k = 1; k < NM; k++) begin
      if (!found && req[(int'(aowner_q) + k) % NM]) begin
        win   = MW'((int'(aowner_q) + k) % NM);
        found = 1'b1;
      end
    end
    dvld_d   = bus.s_hready ? bus.s_htrans[1] : dvld_q;
    downer_d = bus.s_hready ? aowner_q : downer_q;
    aowner_d = (bus.s_hready && own_trans == 2'b00 && !bus.m_hmastlock[aowner_q] && found) ? win : aowner_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aowner_q <= '0;
      downer_q <= '0;
      dvld_q   <= 1'b0;
    end else begin
      aowner_q <= aowner_d;
      downer_q <= downer_d;
      dvld_q   <= dvld_d;
    end
  end
endmodule

// File: tb/tb_ahb_mst_arb.sv
// tb_ahb_mst_arb: scoreboard bench for ahb_mst_arb, NM=2 transfer scenarios plus NM=3 rotation order
module tb_ahb_mst_arb;
  typedef struct { logic [1:0] tr; logic [31:0] ad; logic lk; } beat_t;
  typedef struct { int m; logic [31:0] a; logic lk; } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  ahb_mst_arb_if #(.NM(2), .AW(32), .DW(64)) bus ();
  ahb_mst_arb_if #(.NM(3), .AW(32), .DW(64)) bus3 ();
  ahb_mst_arb #(.NM(2), .AW(32), .DW(64)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  ahb_mst_arb #(.NM(3), .AW(32), .DW(64)) dut3 (.clk(clk), .resetn(resetn), .bus(bus3));
  beat_t q0[$], q1[$];
  exp_t sb[$];
  logic hq[$], rq[$];
  logic [1:0] rdy, rsp;
  logic mst;
  logic [63:0] wd0 = '0, wd1 = '0, wexp = '0;
  logic dpend = 1'b0;
  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] wpat(input int m, input logic [31:0] a);
    return {32'(m) ^ 32'hC0DE_0000, a};
  endfunction
  function automatic logic [12:0] ctl(input int m);
    return (m == 1) ? {1'b1, 3'd2, 3'd1, 4'hC, 2'b11} : {1'b1, 3'd3, 3'd3, 4'h3, 2'b11};
  endfunction
  function automatic beat_t bt(input logic [1:0] tr, input logic [31:0] ad, input logic lk);
    beat_t b;
    b.tr = tr;
    b.ad = ad;
    b.lk = lk;
    return b;
  endfunction
  task automatic burst(input int m, input logic [31:0] a, input int n, input logic lk);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.m = m;
      e.a = a + 32'(8*k);
      e.lk = lk;
      if (m == 1) q1.push_back(bt(k != 0 ? 2'b11 : 2'b10, e.a, lk));
      else q0.push_back(bt(k != 0 ? 2'b11 : 2'b10, e.a, lk));
      sb.push_back(e);
    end
  endtask
  task automatic idle(input int m, input int n, input logic lk);
    for (int k = 0; k < n; k++) begin
      if (m == 1) q1.push_back(bt(2'b00, 32'h0, lk));
      else q0.push_back(bt(2'b00, 32'h0, lk));
    end
  endtask
  task automatic drive();
    beat_t b0, b1;
    b0 = q0.size() != 0 ? q0[0] : bt(2'b00, 32'h0, 1'b0);
    b1 = q1.size() != 0 ? q1[0] : bt(2'b00, 32'h0, 1'b0);
    bus.m_htrans = {b1.tr, b0.tr};
    bus.m_haddr = {b1.ad, b0.ad};
    bus.m_hmastlock = {b1.lk, b0.lk};
    bus.m_hwdata = {wd1, wd0};
    bus.s_hready = hq.size() != 0 ? hq[0] : 1'b1;
    bus.s_hresp = rq.size() != 0 ? rq[0] : 1'b0;
  endtask
  task automatic step();
    exp_t e;
    @(negedge clk);
    rdy = bus.m_hready;
    rsp = bus.m_hresp;
    mst = bus.s_hmaster;
    if (bus.s_hready && dpend) begin
      chk("wdata", bus.s_hwdata, wexp);
      dpend = 1'b0;
    end
    if (bus.s_hready && bus.s_htrans[1]) begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '{-1, 32'h0, 1'b0};
      chk("hmaster", 64'(bus.s_hmaster), 64'(e.m));
      chk("haddr", 64'(bus.s_haddr), 64'(e.a));
      chk("ctl", 64'({bus.s_hwrite, bus.s_hsize, bus.s_hburst, bus.s_hprot, bus.s_hsel, bus.s_hreadym}), 64'(ctl(e.m)));
      chk("lock", 64'(bus.s_hmastlock), 64'(e.lk));
      wexp = wpat(e.m, e.a);
      dpend = 1'b1;
    end
    @(posedge clk);
    #1;
    if (rdy[0] && q0.size() != 0) begin
      if (q0[0].tr[1]) wd0 = wpat(0, q0[0].ad);
      void'(q0.pop_front());
    end
    if (rdy[1] && q1.size() != 0) begin
      if (q1[0].tr[1]) wd1 = wpat(1, q1[0].ad);
      void'(q1.pop_front());
    end
    if (hq.size() != 0) void'(hq.pop_front());
    if (rq.size() != 0) void'(rq.pop_front());
    drive();
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  initial begin
    int c, n;
    logic [5:0] tr;
    int sb3[$];
    bus.m_hwrite = 2'b11;
    bus.m_hsize = {3'd2, 3'd3};
    bus.m_hburst = {3'd1, 3'd3};
    bus.m_hprot = {4'hC, 4'h3};
    bus.s_hrdata = 64'hFACE_0123_4567_89AB;
    bus3.m_htrans = '0;
    bus3.m_haddr = {32'h3000, 32'h2000, 32'h1000};
    bus3.m_hwrite = '0;
    bus3.m_hsize = '0;
    bus3.m_hburst = '0;
    bus3.m_hprot = '0;
    bus3.m_hmastlock = '0;
    bus3.m_hwdata = '0;
    bus3.s_hready = 1'b1;
    bus3.s_hresp = 1'b0;
    bus3.s_hrdata = '0;
    drive();
    bus.s_hresp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_trans", 64'(bus.s_htrans), 64'(0));
    chk("rst_rdy", 64'(bus.m_hready), 64'(3));
    chk("rst_resp", 64'(bus.m_hresp), 64'(0));
    chk("rst_mst", 64'(bus.s_hmaster), 64'(0));
    chk("rdata", bus.m_hrdata, 64'hFACE_0123_4567_89AB);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    drive();
    burst(0, 32'h1000, 4, 1'b0);
    idle(0, 1, 1'b0);
    drive();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("a_m1_rdy", 64'(rdy[1]), 64'(1));
    end
    run(2);
    burst(0, 32'h3000, 8, 1'b0);
    idle(0, 1, 1'b0);
    burst(1, 32'h2000, 1, 1'b0);
    idle(1, 1, 1'b0);
    drive();
    for (int k = 0; k < 8; k++) begin
      step();
      chk("b_m1_stall", 64'(rdy[1]), 64'(0));
    end
    step();
    chk("b_m0_last_rdy", 64'(rdy[0]), 64'(1));
    step();
    chk("b_switch", 64'(mst), 64'(1));
    run(3);
    for (int k = 0; k < 3; k++) begin
      burst(1, 32'hB000 + 32'(16*k), 1, 1'b0);
      idle(1, 1, 1'b0);
      burst(0, 32'hA000 + 32'(16*k), 1, 1'b0);
      idle(0, 1, 1'b0);
    end
    drive();
    run(14);
    burst(0, 32'h4000, 1, 1'b1);
    idle(0, 2, 1'b1);
    burst(0, 32'h4004, 1, 1'b1);
    idle(0, 1, 1'b1);
    idle(0, 1, 1'b0);
    burst(1, 32'h5000, 1, 1'b0);
    idle(1, 1, 1'b0);
    drive();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("d_lock_hold", 64'(rdy[1]), 64'(0));
    end
    step();
    chk("d_grant", 64'(mst), 64'(1));
    run(2);
    burst(0, 32'h6000, 1, 1'b0);
    idle(0, 6, 1'b0);
    idle(1, 2, 1'b0);
    burst(1, 32'h7000, 1, 1'b0);
    idle(1, 1, 1'b0);
    hq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    drive();
    run(2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("e_hold", 64'(mst), 64'(0));
      chk("e_hresp", 64'(rsp), 64'(k >= 2 ? 1 : 0));
    end
    step();
    chk("e_grant", 64'(mst), 64'(1));
    run(3);
    burst(1, 32'h8000, 4, 1'b0);
    idle(1, 1, 1'b0);
    drive();
    run(2);
    resetn = 1'b0;
    bus.m_hmastlock = 2'b11;
    bus.s_hresp = 1'b1;
    @(negedge clk);
    chk("f_rst_trans", 64'(bus.s_htrans), 64'(0));
    chk("f_rst_rdy", 64'(bus.m_hready), 64'(3));
    chk("f_rst_resp", 64'(bus.m_hresp), 64'(0));
    chk("f_rst_lock", 64'(bus.s_hmastlock), 64'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("f_rst_mst", 64'(bus.s_hmaster), 64'(0));
    chk("f_rst_trans2", 64'(bus.s_htrans), 64'(0));
    chk("f_rst_rdy2", 64'(bus.m_hready), 64'(3));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    q1.delete();
    chk("f_sb_left", 64'(sb.size()), 64'(2));
    sb.delete();
    dpend = 1'b0;
    rq.push_back(1'b1);
    drive();
    step();
    chk("f_dvld", 64'(rsp), 64'(0));
    chk("f_mst", 64'(mst), 64'(0));
    run(2);
    c = 0;
    for (int k = 0; k < 9; k++) begin
      tr = '0;
      for (int i = 0; i < 3; i++) if (i != c && (k % 3 != 2 || i == (c + 2) % 3)) tr[2*i+1] = 1'b1;
      sb3.push_back((k % 3 == 2) ? (c + 2) % 3 : (c + 1) % 3);
      bus3.m_htrans = tr;
      @(posedge clk);
      #1;
      @(negedge clk);
      n = sb3.pop_front();
      chk("rot_owner", 64'(bus3.s_hmaster), 64'(n));
      chk("rot_addr", 64'(bus3.s_haddr), 64'(32'h1000 * (n + 1)));
      c = n;
      @(posedge clk);
      #1;
    end
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
